// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle MIPS-subset controller (FETCH/DECODE/EXE/MEM/WB).
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic       SignExt,
    output logic       LuiExt,
    output logic [1:0] ALUOp,
    output logic       ALUSrc,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] NPCOp,
    output logic [2:0] state,
    output logic       instr_done
);

    localparam logic [2:0] C_FETCH  = 3'd0;
    localparam logic [2:0] C_DECODE = 3'd1;
    localparam logic [2:0] C_EXE    = 3'd2;
    localparam logic [2:0] C_MEM    = 3'd3;
    localparam logic [2:0] C_WB     = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next;

    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
    logic w_illegal;

    assign w_rtype   = (opcode == 6'b000000);
    assign w_addu    = w_rtype && (funct == 6'b100001);
    assign w_subu    = w_rtype && (funct == 6'b100011);
    assign w_jr      = w_rtype && (funct == 6'b001000);
    assign w_ori     = (opcode == 6'b001101);
    assign w_lw      = (opcode == 6'b100011);
    assign w_sw      = (opcode == 6'b101011);
    assign w_beq     = (opcode == 6'b000100);
    assign w_lui     = (opcode == 6'b001111);
    assign w_j       = (opcode == 6'b000010);
    assign w_jal     = (opcode == 6'b000011);
    assign w_illegal = !(w_addu || w_subu || w_jr || w_ori || w_lw || w_sw ||
                         w_beq || w_lui || w_j || w_jal);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = C_FETCH;
        case (r_state)
            C_FETCH:  w_next = C_DECODE;
            C_DECODE: w_next = (w_j || w_jal || w_jr || w_illegal) ? C_FETCH : C_EXE;
            C_EXE: begin
                if (w_beq)              w_next = C_FETCH;
                else if (w_lw || w_sw)  w_next = C_MEM;
                else                    w_next = C_WB;
            end
            C_MEM:    w_next = w_lw ? C_WB : C_FETCH;
            C_WB:     w_next = C_FETCH;
            default:  w_next = C_FETCH;
        endcase
    end

    logic       w_pcwr, w_irwr, w_regwr, w_memwr, w_done;
    logic       w_signext, w_luiext, w_alusrc;
    logic [1:0] w_aluop, w_regdst, w_memtoreg, w_npcop;
    logic       w_exe_phase;

    // ALU/EXT selects stay valid from EXE until the instruction retires.
    assign w_exe_phase = (r_state == C_EXE) || (r_state == C_MEM) || (r_state == C_WB);

    always_comb begin
        w_pcwr     = 1'b0;
        w_irwr     = 1'b0;
        w_regwr    = 1'b0;
        w_memwr    = 1'b0;
        w_done     = 1'b0;
        w_signext  = 1'b0;
        w_luiext   = 1'b0;
        w_alusrc   = 1'b0;
        w_aluop    = 2'd0;
        w_regdst   = 2'd0;
        w_memtoreg = 2'd0;
        w_npcop    = 2'd0;

        if (w_exe_phase) begin
            if (w_subu || w_beq)     w_aluop = 2'd1;
            else if (w_ori || w_lui) w_aluop = 2'd2;
            w_alusrc  = w_lw || w_sw || w_ori || w_lui;
            w_signext = w_lw || w_sw || w_beq;
            w_luiext  = w_lui;
        end

        case (r_state)
            C_FETCH: begin
                w_pcwr = 1'b1;
                w_irwr = 1'b1;
            end
            C_DECODE: begin
                if (w_j) begin
                    w_pcwr  = 1'b1;
                    w_npcop = 2'd2;
                    w_done  = 1'b1;
                end else if (w_jal) begin
                    w_pcwr     = 1'b1;
                    w_npcop    = 2'd2;
                    w_regwr    = 1'b1;
                    w_regdst   = 2'd2;
                    w_memtoreg = 2'd2;
                    w_done     = 1'b1;
                end else if (w_jr) begin
                    w_pcwr  = 1'b1;
                    w_npcop = 2'd3;
                    w_done  = 1'b1;
                end else if (w_illegal) begin
                    w_done = 1'b1;
                end
            end
            C_EXE: begin
                if (w_beq) begin
                    w_pcwr  = zero;
                    w_npcop = 2'd1;
                    w_done  = 1'b1;
                end
            end
            C_MEM: begin
                if (w_sw) begin
                    w_memwr = 1'b1;
                    w_done  = 1'b1;
                end
            end
            C_WB: begin
                w_regwr = 1'b1;
                w_done  = 1'b1;
                if (w_addu || w_subu) begin
                    w_regdst = 2'd1;
                end else if (w_lw) begin
                    w_memtoreg = 2'd1;
                end
            end
            default: begin
                w_pcwr = 1'b0;
            end
        endcase
    end

    assign PCWr       = w_pcwr  && !reset;
    assign IRWr       = w_irwr  && !reset;
    assign RegWr      = w_regwr && !reset;
    assign MemWr      = w_memwr && !reset;
    assign instr_done = w_done  && !reset;
    assign SignExt    = w_signext;
    assign LuiExt     = w_luiext;
    assign ALUOp      = w_aluop;
    assign ALUSrc     = w_alusrc;
    assign RegDst     = w_regdst;
    assign MemtoReg   = w_memtoreg;
    assign NPCOp      = w_npcop;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Table-driven directed check of mc_ctrl plus latency sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    localparam logic [5:0] C_RT  = 6'b000000;
    localparam logic [5:0] C_ORI = 6'b001101;
    localparam logic [5:0] C_LW  = 6'b100011;
    localparam logic [5:0] C_SW  = 6'b101011;
    localparam logic [5:0] C_BEQ = 6'b000100;
    localparam logic [5:0] C_LUI = 6'b001111;
    localparam logic [5:0] C_J   = 6'b000010;
    localparam logic [5:0] C_JAL = 6'b000011;
    localparam logic [5:0] C_BAD = 6'b111111;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_JR   = 6'b001000;

    logic       clk, reset, zero;
    logic [5:0] opcode, funct;
    logic       PCWr, IRWr, RegWr, MemWr, SignExt, LuiExt, ALUSrc, instr_done;
    logic [1:0] ALUOp, RegDst, MemtoReg, NPCOp;
    logic [2:0] state;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .SignExt(SignExt), .LuiExt(LuiExt), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .NPCOp(NPCOp),
        .state(state), .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {PCWr,IRWr,RegWr,MemWr,SignExt,LuiExt,ALUOp,ALUSrc,RegDst,MemtoReg,NPCOp,instr_done}
    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [2:0]  st;
        logic [15:0] ctrl;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] C(input logic pc, ir, rw, mw, se, le,
                                      input logic [1:0] aop, input logic asrc,
                                      input logic [1:0] rd, m2r, npc, input logic dn);
        return {pc, ir, rw, mw, se, le, aop, asrc, rd, m2r, npc, dn};
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, fn, input logic z,
                       input logic [2:0] st, input logic [15:0] ctrl);
        vecs[nvec] = '{rst: rst, op: op, fn: fn, z: z, st: st, ctrl: ctrl};
        nvec++;
    endtask

    function automatic logic [15:0] actual_ctrl();
        return {PCWr, IRWr, RegWr, MemWr, SignExt, LuiExt, ALUOp, ALUSrc,
                RegDst, MemtoReg, NPCOp, instr_done};
    endfunction

    task automatic lat(input logic [5:0] op, fn, input logic z, input int exp_cyc,
                       input string nm);
        int  cyc;
        bit  seen;
        @(negedge clk);
        reset = 1'b1; opcode = op; funct = fn; zero = z;
        @(negedge clk);
        reset = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            #2;
            cyc++;
            if (instr_done) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen || cyc != exp_cyc) begin
            n_bad++;
            $display("FAIL latency_%s: got %0d cycles (done seen=%0d), expected %0d",
                     nm, cyc, seen, exp_cyc);
        end
    endtask

    localparam logic [15:0] Z16 = 16'h0000;

    initial begin
        logic [15:0] fetch_c;
        fetch_c = C(1,1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,0);

        add(1, C_RT,  0, 0, 3'd0, Z16);
        // lw
        add(0, C_LW,  0, 0, 3'd0, fetch_c);
        add(0, C_LW,  0, 0, 3'd1, Z16);
        add(0, C_LW,  0, 0, 3'd2, C(0,0,0,0,1,0,2'd0,1,2'd0,2'd0,2'd0,0));
        add(0, C_LW,  0, 0, 3'd3, C(0,0,0,0,1,0,2'd0,1,2'd0,2'd0,2'd0,0));
        add(0, C_LW,  0, 0, 3'd4, C(0,0,1,0,1,0,2'd0,1,2'd0,2'd1,2'd0,1));
        // beq taken / not taken
        add(0, C_BEQ, 0, 1, 3'd0, fetch_c);
        add(0, C_BEQ, 0, 1, 3'd1, Z16);
        add(0, C_BEQ, 0, 1, 3'd2, C(1,0,0,0,1,0,2'd1,0,2'd0,2'd0,2'd1,1));
        add(0, C_BEQ, 0, 0, 3'd0, fetch_c);
        add(0, C_BEQ, 0, 0, 3'd1, Z16);
        add(0, C_BEQ, 0, 0, 3'd2, C(0,0,0,0,1,0,2'd1,0,2'd0,2'd0,2'd1,1));
        // lui, ori
        add(0, C_LUI, 0, 0, 3'd0, fetch_c);
        add(0, C_LUI, 0, 0, 3'd1, Z16);
        add(0, C_LUI, 0, 0, 3'd2, C(0,0,0,0,0,1,2'd2,1,2'd0,2'd0,2'd0,0));
        add(0, C_LUI, 0, 0, 3'd4, C(0,0,1,0,0,1,2'd2,1,2'd0,2'd0,2'd0,1));
        add(0, C_ORI, 0, 0, 3'd0, fetch_c);
        add(0, C_ORI, 0, 0, 3'd1, Z16);
        add(0, C_ORI, 0, 0, 3'd2, C(0,0,0,0,0,0,2'd2,1,2'd0,2'd0,2'd0,0));
        add(0, C_ORI, 0, 0, 3'd4, C(0,0,1,0,0,0,2'd2,1,2'd0,2'd0,2'd0,1));
        // jumps
        add(0, C_JAL, 0, 0, 3'd0, fetch_c);
        add(0, C_JAL, 0, 0, 3'd1, C(1,0,1,0,0,0,2'd0,0,2'd2,2'd2,2'd2,1));
        add(0, C_J,   0, 0, 3'd0, fetch_c);
        add(0, C_J,   0, 0, 3'd1, C(1,0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd2,1));
        add(0, C_RT, F_JR, 0, 3'd0, fetch_c);
        add(0, C_RT, F_JR, 0, 3'd1, C(1,0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd3,1));
        // addu, subu
        add(0, C_RT, F_ADDU, 0, 3'd0, fetch_c);
        add(0, C_RT, F_ADDU, 0, 3'd1, Z16);
        add(0, C_RT, F_ADDU, 0, 3'd2, Z16);
        add(0, C_RT, F_ADDU, 0, 3'd4, C(0,0,1,0,0,0,2'd0,0,2'd1,2'd0,2'd0,1));
        add(0, C_RT, F_SUBU, 0, 3'd0, fetch_c);
        add(0, C_RT, F_SUBU, 0, 3'd1, Z16);
        add(0, C_RT, F_SUBU, 0, 3'd2, C(0,0,0,0,0,0,2'd1,0,2'd0,2'd0,2'd0,0));
        add(0, C_RT, F_SUBU, 0, 3'd4, C(0,0,1,0,0,0,2'd1,0,2'd1,2'd0,2'd0,1));
        // illegal opcode and illegal R-type funct
        add(0, C_BAD, 0, 0, 3'd0, fetch_c);
        add(0, C_BAD, 0, 0, 3'd1, C(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,1));
        add(0, C_RT,  0, 0, 3'd0, fetch_c);
        add(0, C_RT,  0, 0, 3'd1, C(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,1));
        // sw complete
        add(0, C_SW,  0, 0, 3'd0, fetch_c);
        add(0, C_SW,  0, 0, 3'd1, Z16);
        add(0, C_SW,  0, 0, 3'd2, C(0,0,0,0,1,0,2'd0,1,2'd0,2'd0,2'd0,0));
        add(0, C_SW,  0, 0, 3'd3, C(0,0,0,1,1,0,2'd0,1,2'd0,2'd0,2'd0,1));
        // sw interrupted by reset in MEM
        add(0, C_SW,  0, 0, 3'd0, fetch_c);
        add(0, C_SW,  0, 0, 3'd1, Z16);
        add(0, C_SW,  0, 0, 3'd2, C(0,0,0,0,1,0,2'd0,1,2'd0,2'd0,2'd0,0));
        add(1, C_SW,  0, 0, 3'd3, C(0,0,0,0,1,0,2'd0,1,2'd0,2'd0,2'd0,0));
        add(1, C_SW,  0, 0, 3'd0, Z16);
        add(0, C_SW,  0, 0, 3'd0, fetch_c);

        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            reset  = vecs[i].rst;
            opcode = vecs[i].op;
            funct  = vecs[i].fn;
            zero   = vecs[i].z;
            #2;
            n_cmp++;
            if (state !== vecs[i].st || actual_ctrl() !== vecs[i].ctrl) begin
                n_bad++;
                $display("FAIL vec%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, actual_ctrl(), vecs[i].st, vecs[i].ctrl);
            end
        end

        lat(C_LW,  0,      0, 5, "lw");
        lat(C_SW,  0,      0, 4, "sw");
        lat(C_RT,  F_ADDU, 0, 4, "addu");
        lat(C_RT,  F_SUBU, 0, 4, "subu");
        lat(C_ORI, 0,      0, 4, "ori");
        lat(C_LUI, 0,      0, 4, "lui");
        lat(C_BEQ, 0,      1, 3, "beq_t");
        lat(C_BEQ, 0,      0, 3, "beq_nt");
        lat(C_J,   0,      0, 2, "j");
        lat(C_JAL, 0,      0, 2, "jal");
        lat(C_RT,  F_JR,   0, 2, "jr");
        lat(C_BAD, 0,      0, 2, "illegal");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (ports clk and reset).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 opcode  input  6  instruction bits [31:26] from the datapath IR, stable from DECODE onward.
REQ-005 funct  input  6  instruction bits [5:0] from the IR.
REQ-006 zero  input  1  ALU equality flag from the datapath.
REQ-007 PCWr  output  1  PC write enable.
REQ-008 IRWr  output  1  IR write enable.
REQ-009 RegWr  output  1  register-file write enable.
REQ-010 MemWr  output  1  data-memory write enable.
REQ-011 SignExt  output  1  EXT sign-extend select (0 = zero-extend).
REQ-012 LuiExt  output  1  EXT lui select (imm16 << 16); it has priority over SignExt in EXT.
REQ-013 ALUOp  output  2  0 = add, 1 = sub, 2 = or.
REQ-014 ALUSrc  output  1  0 = rt register, 1 = EXT output.
REQ-015 RegDst  output  2  0 = rt, 1 = rd, 2 = $31.
REQ-016 MemtoReg  output  2  0 = ALU result, 1 = memory data, 2 = PC+4.
REQ-017 NPCOp  output  2  0 = PC+4, 1 = branch, 2 = j/jal target, 3 = rs (jr).
REQ-018 state  output  3  current state encoding, for debug.
REQ-019 instr_done  output  1  one-cycle pulse on the last cycle of each instruction, including illegal instructions.

Function
REQ-020 The state register SHALL hold one of FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4; other codes SHALL go to FETCH on the next edge.
REQ-021 Supported instructions: addu (op 000000, funct 100001), subu (000000/100011), jr (000000/001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011; every other opcode/funct pair SHALL be illegal.
REQ-022 Outputs SHALL be combinational from the state, opcode, funct and zero; outputs not listed for a state SHALL be 0.
REQ-023 FETCH: PCWr=1, IRWr=1, NPCOp=0; next state DECODE.
REQ-024 DECODE, j: PCWr=1, NPCOp=2, instr_done=1; next state FETCH.
REQ-025 DECODE, jal: PCWr=1, NPCOp=2, RegWr=1, RegDst=2, MemtoReg=2, instr_done=1; next state FETCH.
REQ-026 DECODE, jr: PCWr=1, NPCOp=3, instr_done=1; next state FETCH.
REQ-027 DECODE, illegal instruction: no write enables, instr_done=1; next state FETCH, so it acts as a 2-cycle nop.
REQ-028 DECODE, any other instruction: next state EXE.
REQ-029 EXE, beq: ALUOp=1, ALUSrc=0, SignExt=1, NPCOp=1, PCWr=zero, instr_done=1; next state FETCH.
REQ-030 EXE, lw/sw: ALUOp=0, ALUSrc=1, SignExt=1; next state MEM.
REQ-031 EXE, addu/subu: ALUOp=0/1, ALUSrc=0; next state WB.
REQ-032 EXE, ori: ALUOp=2, ALUSrc=1, SignExt=0, LuiExt=0; next state WB.
REQ-033 EXE, lui: ALUOp=2, ALUSrc=1, LuiExt=1 (rs = $0 in the ISA); next state WB.
REQ-034 MEM, sw: MemWr=1, instr_done=1; next state FETCH.
REQ-035 MEM, lw: no enables; next state WB.
REQ-036 WB: RegWr=1, instr_done=1; RegDst=1 and MemtoReg=0 for R-type, RegDst=0 and MemtoReg=1 for lw, RegDst=0 and MemtoReg=0 for ori/lui; next state FETCH.
REQ-037 EXT and ALU select outputs SHALL be held at their EXE values through MEM and WB of the same instruction.
REQ-038 Latency in cycles SHALL be: j/jal/jr/illegal 2, beq 3, addu/subu/ori/lui/sw 4, lw 5.

Reset
REQ-039 When reset is sampled high, state SHALL become FETCH on that edge, from any state, including mid-instruction.
REQ-040 While reset is high, PCWr, IRWr, RegWr, MemWr and instr_done SHALL be forced to 0 regardless of state.
REQ-041 The first FETCH cycle SHALL be the first cycle after reset is sampled low.

Verification
REQ-042 Reset, then lw (op 100011) -> state sequence 0,1,2,3,4,0; RegWr=1 and MemtoReg=1 only in WB; SignExt=1 in EXE.
REQ-043 beq with zero=1, then beq with zero=0 -> PCWr=1 (NPCOp=1) in the first EXE, PCWr=0 in the second; 3 cycles each.
REQ-044 lui (001111), then ori (001101) -> LuiExt=1 in lui EXE/WB; SignExt=0 and LuiExt=0 in ori EXE/WB; RegDst=0 in WB for both.
REQ-045 jal -> in DECODE: PCWr=1, RegWr=1, RegDst=2, MemtoReg=2, NPCOp=2; next state FETCH.
REQ-046 Illegal opcode 111111, then reset asserted in the MEM state of sw -> nop takes 2 cycles with no enables; MemWr never asserts and state=0 after the reset edge.
